// File: rtl/packetizer_s2mm.sv
// Cuts a continuous sample stream into packets of config_reg beats, marking the last beat with tlast.
// Zero-latency combinational pass-through: no buffering, data out and valid out follow the input in the same cycle.
// Backpressure: s_axis_data_tready mirrors m_axis_s2mm_tready; both sides stall while the effective length is 0 or reset is held.
module packetizer_s2mm #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic                  m_axis_s2mm_tvalid,
    input  logic                  m_axis_s2mm_tready,
    output logic                  m_axis_s2mm_tlast,
    input  logic [CNT_WIDTH-1:0]  config_reg,
    output logic [CNT_WIDTH-1:0]  counter
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] len_eff;
    logic                 at_boundary;
    logic                 enable;
    logic                 is_last;
    logic                 beat;

    // Length in force for the current beat: live config at a packet boundary, latched length mid-packet.
    // Reset forces both stream sides idle even if config_reg is already non-zero.
    always_comb begin
        at_boundary = (counter == '0);
        len_eff     = at_boundary ? config_reg : len_q;
        enable      = (len_eff != '0) && !areset;
        is_last     = (counter == (len_eff - CNT_ONE));
    end

    assign m_axis_s2mm_tdata  = s_axis_data_tdata;
    assign m_axis_s2mm_tvalid = s_axis_data_tvalid & enable;
    assign s_axis_data_tready = m_axis_s2mm_tready & enable;
    assign m_axis_s2mm_tlast  = m_axis_s2mm_tvalid & is_last;
    assign beat               = m_axis_s2mm_tvalid & m_axis_s2mm_tready;

    // Beat counter wraps on the last beat; the packet length is captured on each packet's first beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            counter <= '0;
            len_q   <= '0;
        end else if (beat) begin
            if (at_boundary) begin
                len_q <= config_reg;
            end
            if (is_last) begin
                counter <= '0;
            end else begin
                counter <= counter + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_packetizer_s2mm.sv
// Randomized bench for packetizer_s2mm against a packet-position reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every cycle compares valid/ready/tlast/counter and, on valid cycles, the forwarded data.
module tb_packetizer_s2mm;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axis_data_tdata;
    logic        s_axis_data_tvalid;
    logic        s_axis_data_tready;
    logic [31:0] m_axis_s2mm_tdata;
    logic        m_axis_s2mm_tvalid;
    logic        m_axis_s2mm_tready;
    logic        m_axis_s2mm_tlast;
    logic [31:0] config_reg;
    logic [31:0] counter;

    packetizer_s2mm #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .m_axis_s2mm_tdata  (m_axis_s2mm_tdata),
        .m_axis_s2mm_tvalid (m_axis_s2mm_tvalid),
        .m_axis_s2mm_tready (m_axis_s2mm_tready),
        .m_axis_s2mm_tlast  (m_axis_s2mm_tlast),
        .config_reg         (config_reg),
        .counter            (counter)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position of the next beat within its packet, and the
    // length the packet was started with. A new packet takes the live config.
    longint unsigned pos      = 0;
    longint unsigned pkt_len  = 0;
    int              n_beats  = 0;
    int              n_lasts  = 0;
    int              sent_cnt = 0;
    int              recv_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model at the falling edge, then
    // advance the model across the rising edge if a beat was accepted.
    task automatic tick();
        longint unsigned eff;
        logic            en, exp_v, exp_r, exp_l, acc;
        @(negedge aclk);
        eff = (pos == 0) ? longint'(config_reg) : pkt_len;
        en  = (eff != 0) && !areset;
        exp_v = s_axis_data_tvalid && en;
        exp_r = m_axis_s2mm_tready && en;
        exp_l = exp_v && (pos + 1 == eff);
        check_eq("tvalid", {63'd0, m_axis_s2mm_tvalid}, {63'd0, exp_v});
        check_eq("tready", {63'd0, s_axis_data_tready}, {63'd0, exp_r});
        check_eq("tlast", {63'd0, m_axis_s2mm_tlast}, {63'd0, exp_l});
        check_eq("counter", {32'd0, counter}, areset ? 64'd0 : pos);
        if (exp_v) begin
            check_eq("tdata", {32'd0, m_axis_s2mm_tdata}, {32'd0, s_axis_data_tdata});
        end
        acc = exp_v && m_axis_s2mm_tready;
        if (s_axis_data_tvalid && s_axis_data_tready) sent_cnt++;
        if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) recv_cnt++;
        @(posedge aclk);
        if (acc && !areset) begin
            n_beats++;
            if (pos == 0) pkt_len = longint'(config_reg);
            if (pos + 1 == pkt_len) begin
                pos = 0;
                n_lasts++;
            end else begin
                pos++;
            end
        end
        #1;
    endtask

    initial begin
        int budget;
        int lasts0;

        areset             = 1'b1;
        s_axis_data_tdata  = 32'h0;
        s_axis_data_tvalid = 1'b0;
        m_axis_s2mm_tready = 1'b1;
        config_reg         = 32'd5;
        s_axis_data_tvalid = 1'b1;
        tick();
        tick();

        // Disabled stream: config 0 must stall both sides with counter at 0.
        config_reg = 32'd0;
        areset     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_axis_data_tdata  = $urandom;
            s_axis_data_tvalid = 1'b1;
            tick();
        end
        check_eq("no_beats_disabled", 64'(n_beats), 64'd0);

        // Length 10, source valid every other cycle, sink always ready.
        config_reg         = 32'd10;
        m_axis_s2mm_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_axis_data_tdata  = $urandom;
            s_axis_data_tvalid = i[0] == 1'b0;
            tick();
        end
        check_eq("lasts_len10", 64'(n_lasts), 64'd2);

        // Length 4, continuous flow: three packets.
        config_reg = 32'd4;
        lasts0     = n_lasts;
        for (int i = 0; i < 12; i++) begin
            s_axis_data_tdata  = $urandom;
            s_axis_data_tvalid = 1'b1;
            tick();
        end
        check_eq("lasts_len4", 64'(n_lasts - lasts0), 64'd3);

        // Length change mid-packet: 10 -> 3 after beat 5 of a packet.
        config_reg = 32'd10;
        budget     = 100;
        s_axis_data_tvalid = 1'b1;
        while (pos != 5 && budget > 0) begin
            s_axis_data_tdata = $urandom;
            tick();
            budget--;
        end
        check_eq("reach_pos5", 64'(budget > 0), 64'd1);
        config_reg = 32'd3;
        for (int i = 0; i < 20; i++) begin
            s_axis_data_tdata  = $urandom;
            s_axis_data_tvalid = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Length 1 with random sink backpressure: every beat carries tlast.
        config_reg = 32'd1;
        budget     = 20;
        while (pos != 0 && budget > 0) begin
            s_axis_data_tdata = $urandom;
            tick();
            budget--;
        end
        lasts0 = n_lasts;
        n_beats = 0;
        for (int i = 0; i < 40; i++) begin
            s_axis_data_tdata  = $urandom;
            s_axis_data_tvalid = ($urandom_range(0, 3) != 0);
            m_axis_s2mm_tready = $urandom_range(0, 1) == 1;
            tick();
        end
        check_eq("len1_all_last", 64'(n_lasts - lasts0), 64'(n_beats));

        // Reset in the middle of a packet at counter 6.
        config_reg         = 32'd10;
        m_axis_s2mm_tready = 1'b1;
        s_axis_data_tvalid = 1'b1;
        budget             = 100;
        while (pos != 6 && budget > 0) begin
            s_axis_data_tdata = $urandom;
            tick();
            budget--;
        end
        check_eq("reach_pos6", 64'(budget > 0), 64'd1);
        areset = 1'b1;
        pos    = 0;
        #1;
        check_eq("rst_counter", {32'd0, counter}, 64'd0);
        check_eq("rst_tvalid", {63'd0, m_axis_s2mm_tvalid}, 64'd0);
        check_eq("rst_tready", {63'd0, s_axis_data_tready}, 64'd0);
        tick();
        areset  = 1'b0;
        n_beats = 0;
        lasts0  = n_lasts;
        for (int i = 0; i < 10; i++) begin
            s_axis_data_tdata = $urandom;
            tick();
        end
        check_eq("post_rst_beats", 64'(n_beats), 64'd10);
        check_eq("post_rst_one_last", 64'(n_lasts - lasts0), 64'd1);

        check_eq("no_loss", 64'(recv_cnt), 64'(sent_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/packetizer_s2mm.md
Name: packetizer_s2mm

Overview:
- AXI-Stream pass-through that cuts a continuous 32-bit sample stream into packets of programmable length for an S2MM DMA channel.
- Asserts tlast on the final beat of each packet.
- Exposes the beat count within the current packet.
- Sits between the ADC sample stream and the AXI DMA S2MM port.
- Packet length comes from a software configuration register.

Parameters:
- DATA_WIDTH, 32, width of tdata on both streams.
- CNT_WIDTH, 32, width of config_reg, counter and the internal length register.

Ports:
- aclk  in  1  single clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_data_tdata  in  DATA_WIDTH  input sample data.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tready  out  1  input ready.
- m_axis_s2mm_tdata  out  DATA_WIDTH  output data to DMA.
- m_axis_s2mm_tvalid  out  1  output valid.
- m_axis_s2mm_tready  in  1  output ready.
- m_axis_s2mm_tlast  out  1  end-of-packet marker.
- config_reg  in  CNT_WIDTH  packet length in beats; 0 = disabled.
- counter  out  CNT_WIDTH  number of beats already transferred in the current packet.

Behaviour:
- Reset (areset=1, asynchronous): counter=0, len_q=0.
  - Outputs during reset: s_axis_data_tready=0, m_axis_s2mm_tvalid=0, m_axis_s2mm_tlast=0.
- Effective length:
  - len_eff = config_reg when counter==0 (packet boundary); otherwise len_eff = len_q.
  - len_q loads config_reg on the first beat of every packet (handshake while counter==0).
  - config_reg changes mid-packet do not affect the current packet. They take effect at the next boundary.
- enable = (len_eff != 0).
- Datapath is combinational, zero latency, no buffering:
  - m_axis_s2mm_tdata = s_axis_data_tdata.
  - m_axis_s2mm_tvalid = s_axis_data_tvalid & enable.
  - s_axis_data_tready = m_axis_s2mm_tready & enable.
  - Data is never dropped or duplicated.
- Handshake (beat) = m_axis_s2mm_tvalid & m_axis_s2mm_tready.
- tlast = m_axis_s2mm_tvalid & (counter == len_eff-1). It is combinational and valid only with tvalid.
- Counter update on each beat:
  - If counter == len_eff-1: counter <= 0 (packet complete, wrap).
  - Otherwise counter <= counter+1.
  - No change without a beat.
- counter is registered. It reads 1 in the cycle after the first beat of a packet.
- len_eff=1: every beat carries tlast; counter stays 0.
- config_reg=0 at a boundary: stream stalled. tready=0, tvalid=0, counter holds 0.
- Upstream tvalid low mid-packet: counter holds and the packet resumes. No timeout.
- Downstream backpressure: tvalid held by the source, tready follows m_axis_s2mm_tready. Counter holds.
- Reset mid-packet: counter returns to 0. The next beat starts a new packet with the then-current config_reg.
- Maximum length 2^CNT_WIDTH-1 beats. Arithmetic is unsigned, CNT_WIDTH bits.

Test Plan:
- Reset, config_reg=0, source valid with random data -> no beats, s_axis_data_tready=0, counter=0.
- Source alternating valid (1 beat per 2 cycles), sink always ready, config_reg set to 10 -> counter=1 one cycle after the first beat.
  - Same setup, continued: tlast high on beat 10 only, counter back to 0, data at sink matches source beat by beat.
- Continuous valid/ready, config_reg=4 -> tlast on beats 4, 8, 12; counter sequence 0,1,2,3,0,...
- config_reg changed 10->3 after beat 5 -> current packet ends at beat 10 with tlast; the next packet ends after 3 beats.
- Sink tready toggled randomly with config_reg=1 -> every accepted beat has tlast; counter stays 0; no data loss.
- areset asserted mid-packet (counter=6) -> counter=0 immediately, tvalid/tready low; after release a full 10-beat packet precedes the next tlast.
